// File: rtl/dual_port_ram_fifo_ctrl_if.sv
// Request/status bundle between a FIFO user, the pointer controller and the dual-port RAM.
// The controller takes the slave side; the producer/consumer (and RAM hookup) takes the master side.
interface dual_port_ram_fifo_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  wr;
    logic                  rd;
    logic                  we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, rd,
        input  we, w_addr, r_addr, rd_valid, full, empty,
               almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr, rd,
        output we, w_addr, r_addr, rd_valid, full, empty,
               almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/dual_port_ram_fifo_ctrl.sv
// Pointer/flag controller turning a dual-port RAM with registered old-data read into a FIFO.
// Drives RAM write enable and addresses; status flags and rd_valid are registered.
module dual_port_ram_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned ALMOST_FULL_TH  = 2**ADDR_WIDTH - 4,
    parameter int unsigned ALMOST_EMPTY_TH = 4
) (
    input logic                      clk,
    input logic                      reset,
    dual_port_ram_fifo_ctrl_if.slave bus
);
    localparam int unsigned PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);
    localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

    logic [PW-1:0] w_ptr, r_ptr, count;
    logic [PW-1:0] w_ptr_nxt, r_ptr_nxt, count_nxt;
    logic          full, empty, almost_full, almost_empty;
    logic          full_nxt, empty_nxt, almost_full_nxt, almost_empty_nxt;
    logic          rd_valid, overflow, underflow;
    logic          overflow_nxt, underflow_nxt;
    logic          rd_ok, wr_ok;

    // Acceptance and next-state; a pop frees the slot a simultaneous push needs when full.
    always_comb begin
        rd_ok         = bus.rd & ~empty;
        wr_ok         = bus.wr & (~full | rd_ok);
        w_ptr_nxt     = w_ptr;
        r_ptr_nxt     = r_ptr;
        count_nxt     = count;
        overflow_nxt  = overflow;
        underflow_nxt = underflow;

        if (wr_ok) w_ptr_nxt = w_ptr + PW'(1);
        if (rd_ok) r_ptr_nxt = r_ptr + PW'(1);

        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + PW'(1);
            2'b01:   count_nxt = count - PW'(1);
            default: count_nxt = count;
        endcase

        if (bus.wr & ~wr_ok) overflow_nxt  = 1'b1;
        if (bus.rd & ~rd_ok) underflow_nxt = 1'b1;

        // Full/empty from the wrap bit so they need no extra compare against depth.
        full_nxt         = (w_ptr_nxt[PW-1] != r_ptr_nxt[PW-1]) &&
                           (w_ptr_nxt[PW-2:0] == r_ptr_nxt[PW-2:0]);
        empty_nxt        = (w_ptr_nxt == r_ptr_nxt);
        almost_full_nxt  = (count_nxt >= AF_TH);
        almost_empty_nxt = (count_nxt <= AE_TH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            w_ptr        <= w_ptr_nxt;
            r_ptr        <= r_ptr_nxt;
            count        <= count_nxt;
            full         <= full_nxt;
            empty        <= empty_nxt;
            almost_full  <= almost_full_nxt;
            almost_empty <= almost_empty_nxt;
            rd_valid     <= rd_ok;
            overflow     <= overflow_nxt;
            underflow    <= underflow_nxt;
        end
    end

    assign bus.we           = wr_ok;
    assign bus.w_addr       = w_ptr[PW-2:0];
    assign bus.r_addr       = r_ptr[PW-2:0];
    assign bus.rd_valid     = rd_valid;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = almost_full;
    assign bus.almost_empty = almost_empty;
    assign bus.count        = count;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: tb/tb_dual_port_ram_fifo_ctrl.sv
// Bench for dual_port_ram_fifo_ctrl with a depth-4 FIFO and an old-data-read RAM alongside.
// Table vectors, directed corner sequences and random traffic against a queue model.
module tb_dual_port_ram_fifo_ctrl;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic [7:0] mem [DEPTH];
    logic [7:0] q;

    int n_vec = 0;
    int n_err = 0;

    dual_port_ram_fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    dual_port_ram_fifo_ctrl #(
        .ADDR_WIDTH     (AW),
        .ALMOST_FULL_TH (3),
        .ALMOST_EMPTY_TH(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // RAM with registered read returning the pre-write contents on address collision
    always_ff @(posedge clk) begin
        if (bus.we) mem[bus.w_addr] <= din;
        q <= mem[bus.r_addr];
    end

    typedef struct {
        logic       wr, rd;
        logic [7:0] d;
        logic [2:0] count;
        logic       full, empty, af, ae, rv, ov, un;
        logic [7:0] q;
    } vec_t;

    vec_t tbl [10];

    // Reference model: plain queue plus sticky error bits
    logic [7:0] mq [$];
    logic       m_ov, m_un;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        bus.wr = w;
        bus.rd = r;
        din    = d;
    endtask

    task automatic model_clear();
        mq.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_ae", 32'(bus.almost_empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_rv", 32'(bus.rd_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic mstep(input logic w, input logic r, input logic [7:0] d);
        logic       rok, wok;
        logic [7:0] hd;
        drive(w, r, d);
        rok = r && (mq.size() != 0);
        wok = w && ((mq.size() < DEPTH) || rok);
        hd  = 8'h00;
        #1 chk("we", 32'(bus.we), 32'(wok));
        if (rok) hd = mq.pop_front();
        if (wok) mq.push_back(d);
        if (w && !wok) m_ov = 1'b1;
        if (r && !rok) m_un = 1'b1;
        @(posedge clk);
        #1;
        chk("count", 32'(bus.count), 32'(mq.size()));
        chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
        chk("almost_full", 32'(bus.almost_full), 32'(mq.size() >= 3));
        chk("almost_empty", 32'(bus.almost_empty), 32'(mq.size() <= 1));
        chk("rd_valid", 32'(bus.rd_valid), 32'(rok));
        chk("overflow", 32'(bus.overflow), 32'(m_ov));
        chk("underflow", 32'(bus.underflow), 32'(m_un));
        if (rok) chk("q", 32'(q), 32'(hd));
    endtask

    initial begin
        reset  = 1'b1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        din    = 8'h00;
        model_clear();

        //             wr rd d       cnt  full empty af ae rv ov un q
        tbl[0] = '{1'b1, 1'b0, 8'hA1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 8'hB2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 8'hC3, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 8'hD4, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b1, 1'b0, 8'h55, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[5] = '{1'b0, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA1};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hB2};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC3};
        tbl[8] = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hD4};
        tbl[9] = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_count", 32'(bus.count), 0);
        chk("idle_empty", 32'(bus.empty), 1);
        chk("idle_ae", 32'(bus.almost_empty), 1);
        chk("idle_full", 32'(bus.full), 0);
        chk("idle_rv", 32'(bus.rd_valid), 0);

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].d);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_count", i), 32'(bus.count), 32'(tbl[i].count));
            chk($sformatf("tbl%0d_full", i), 32'(bus.full), 32'(tbl[i].full));
            chk($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].empty));
            chk($sformatf("tbl%0d_af", i), 32'(bus.almost_full), 32'(tbl[i].af));
            chk($sformatf("tbl%0d_ae", i), 32'(bus.almost_empty), 32'(tbl[i].ae));
            chk($sformatf("tbl%0d_rv", i), 32'(bus.rd_valid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_ov", i), 32'(bus.overflow), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_un", i), 32'(bus.underflow), 32'(tbl[i].un));
            if (tbl[i].rv) chk($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].q));
        end

        // Reset mid-burst while rd_valid and both sticky flags are high
        drive(1'b1, 1'b0, 8'h21);
        drive(1'b1, 1'b0, 8'h22);
        drive(1'b1, 1'b1, 8'h23);
        @(posedge clk);
        #1 chk("burst_rv", 32'(bus.rd_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_count", 32'(bus.count), 0);
        chk("mid_empty", 32'(bus.empty), 1);
        chk("mid_ae", 32'(bus.almost_empty), 1);
        chk("mid_full", 32'(bus.full), 0);
        chk("mid_af", 32'(bus.almost_full), 0);
        chk("mid_rv", 32'(bus.rd_valid), 0);
        chk("mid_ov", 32'(bus.overflow), 0);
        chk("mid_un", 32'(bus.underflow), 0);
        chk("mid_raddr", 32'(bus.r_addr), 0);
        @(negedge clk);
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        reset  = 1'b0;
        model_clear();

        // Full FIFO with simultaneous push and pop, then drain
        mstep(1'b1, 1'b0, 8'hA1);
        mstep(1'b1, 1'b0, 8'hB2);
        mstep(1'b1, 1'b0, 8'hC3);
        mstep(1'b1, 1'b0, 8'hD4);
        mstep(1'b1, 1'b1, 8'hE5);
        for (int i = 0; i < 4; i++) mstep(1'b0, 1'b1, 8'h00);

        // Empty FIFO with simultaneous push and pop: only the push lands
        mstep(1'b1, 1'b1, 8'h11);
        mstep(1'b0, 1'b1, 8'h00);

        // Ten single push/pop pairs to wrap both pointers
        do_reset();
        for (int i = 0; i < 10; i++) begin
            mstep(1'b1, 1'b0, 8'(8'h30 + i));
            mstep(1'b0, 1'b1, 8'h00);
        end

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            mstep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            if (i == 200) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dual_port_ram_fifo_ctrl.md
Name: dual_port_ram_fifo_ctrl

Overview:
- Pointer and flag controller that turns the dual-port RAM with registered, old-data read into a synchronous FIFO.
- Sits directly upstream of the RAM. Drives its write enable, write address and read address from push/pop requests.
- Produces full/empty/almost/count status and a read-valid strobe aligned to the RAM's registered output q.

Parameters:
ADDR_WIDTH, 10, address bits; FIFO depth = 2**ADDR_WIDTH; must match the RAM instance.
ALMOST_FULL_TH, 2**ADDR_WIDTH-4, almost_full asserted when count >= this value.
ALMOST_EMPTY_TH, 4, almost_empty asserted when count <= this value.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-high reset.
wr  input  1  push request; data is presented to the RAM d port by the producer in the same cycle.
rd  input  1  pop request.
we  output  1  RAM write enable (combinational).
w_addr  output  ADDR_WIDTH  RAM write address = low bits of the write pointer (combinational).
r_addr  output  ADDR_WIDTH  RAM read address = low bits of the read pointer (combinational).
rd_valid  output  1  registered; high for one cycle when RAM q holds data from a pop accepted in the previous cycle.
full  output  1  registered; count == 2**ADDR_WIDTH.
empty  output  1  registered; count == 0.
almost_full  output  1  registered threshold flag.
almost_empty  output  1  registered threshold flag.
count  output  ADDR_WIDTH+1  registered occupancy, 0..2**ADDR_WIDTH.
overflow  output  1  sticky; set when wr is rejected.
underflow  output  1  sticky; set when rd is rejected.

Behaviour:
- Pointers: w_ptr and r_ptr are ADDR_WIDTH+1 bits and wrap naturally modulo 2**(ADDR_WIDTH+1).
  - full: MSBs differ and low bits are equal.
  - empty: pointers are equal.
- Reset, asserted at any time including mid-transfer, forces immediately:
  - w_ptr=0, r_ptr=0, count=0
  - empty=1, full=0, almost_empty=1, almost_full=0
  - rd_valid=0, overflow=0, underflow=0
  - RAM contents are not cleared and are treated as undefined.
- Acceptance (wr_ok/rd_ok):
  - rd_ok = rd & ~empty.
  - wr_ok = wr & (~full | rd_ok).
  - When full with wr and rd together, both are accepted. The read and write addresses are equal, and the RAM returns old data, which is the correct FIFO head.
  - When empty with wr and rd together, only the write is accepted.
- Outputs and state updates:
  - we = wr_ok.
  - w_ptr increments on wr_ok; r_ptr increments on rd_ok.
  - count += wr_ok - rd_ok; it is unchanged when both are accepted.
  - Flags are recomputed from the next-state count, so they are valid in the same cycle as count.
- Read latency:
  - The RAM samples r_addr at the edge where rd_ok=1.
  - rd_valid goes high after that edge, together with q, for exactly one cycle per accepted pop.
  - Back-to-back pops give rd_valid high in consecutive cycles.
- Error flags: overflow sets on wr & ~wr_ok; underflow sets on rd & ~rd_ok. Both hold until reset.
  - Rejected requests change no pointer, count or RAM location.
- Thresholds: parameters must satisfy 0 <= ALMOST_EMPTY_TH < ALMOST_FULL_TH <= 2**ADDR_WIDTH. This is not checked in hardware.

Test Plan (ADDR_WIDTH=2, depth 4, ALMOST_FULL_TH=3, ALMOST_EMPTY_TH=1, RAM instantiated alongside):
- Reset, then idle → count=0, empty=1, almost_empty=1, full=0, rd_valid=0. Assert reset mid-burst → all return to reset values at once.
- Push 0xA1,0xB2,0xC3,0xD4 → after the 3rd push almost_full=1; after the 4th full=1, count=4. 5th push → rejected, overflow=1, count stays 4.
- From full, pop 4 times back-to-back → rd_valid high for 4 consecutive cycles, q=0xA1,0xB2,0xC3,0xD4, then empty=1. 5th pop → underflow=1, no rd_valid.
- Full FIFO, simultaneous wr(0xE5)+rd → q=0xA1 next cycle, count stays 4. Drain → 0xB2,0xC3,0xD4,0xE5.
- Empty FIFO, simultaneous wr(0x11)+rd → only the write is accepted, no rd_valid, count=1, underflow=1.
- Push/pop 10 items one at a time → pointers wrap past 7→0, data order preserved, flags correct throughout.
